// File: rtl/bus_pkg.sv
// ============================================================================
// Module   : bus (package)
// Purpose  : Shared types and constants for the CPU-to-Wishbone bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RESPOND = 2'd2
    } bridge_state_t;

    // Widest byte address the request struct can carry; narrower buses zero-extend.
    localparam int MAX_ADDRESS_WIDTH = 64;

    typedef struct packed {
        logic                         we;
        logic [MAX_ADDRESS_WIDTH-3:0] adr;
        logic [31:0]                  dat;
        logic [3:0]                   sel;
    } wishbone_request_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

`default_nettype wire

// File: rtl/wishbone_bridge_if.sv
// ============================================================================
// Module   : wishbone_bridge_if
// Purpose  : Wishbone B4 classic master/slave signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wishbone_bridge_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     wb_cyc;
    logic                     wb_stb;
    logic                     wb_we;
    logic [ADDRESS_WIDTH-3:0] wb_adr;
    logic [31:0]              wb_dat_o;
    logic [3:0]               wb_sel;
    logic [31:0]              wb_dat_i;
    logic                     wb_ack;
    logic                     wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
        input  wb_dat_i, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel,
        output wb_dat_i, wb_ack, wb_err
    );
endinterface

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// Module   : bus_timeout_counter
// Purpose  : Counts wait cycles; flags expiry at TIMEOUT_CYCLES-1 (0 = never).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timeout_counter
    import bus::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int         c_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_WIDTH-1:0] c_LAST = c_WIDTH'(TIMEOUT_CYCLES - 1);

            logic [c_WIDTH-1:0] r_count_q;
            logic [c_WIDTH-1:0] w_count_d;

            always_comb begin
                w_count_d = r_count_q;
                if (clear) begin
                    w_count_d = '0;
                end else if (enable) begin
                    w_count_d = r_count_q + c_WIDTH'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count_q <= '0;
                end else begin
                    r_count_q <= w_count_d;
                end
            end

            assign expired = (r_count_q == c_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wishbone_bridge.sv
// ============================================================================
// Module   : wishbone_bridge
// Purpose  : Turns each CPU data access into one Wishbone classic cycle and
//            stalls the core until ack, err or timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_bridge
    import bus::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ADDRESS_WIDTH  = 32
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     request,
    input  wire logic                     write_enable,
    input  wire logic [ADDRESS_WIDTH-1:0] address,
    input  wire logic [31:0]              write_data,
    input  wire logic [3:0]               byte_select,
    output logic [31:0]                   read_data,
    output logic                          stall,
    output logic                          bus_error,
    wishbone_bridge_if.master             wb
);

    localparam int c_ADR_W = MAX_ADDRESS_WIDTH - 2;

    bridge_state_t     r_state_q;
    bridge_state_t     w_state_d;
    logic              r_cyc_q;
    logic              w_cyc_d;
    wishbone_request_t r_req_q;
    wishbone_request_t w_req_d;
    logic [31:0]       r_read_data_q;
    logic [31:0]       w_read_data_d;
    logic              r_bus_error_q;
    logic              w_bus_error_d;

    logic w_active;
    logic w_expired;
    logic w_done;
    logic w_unused;

    assign w_active = (r_state_q == ACTIVE);
    assign w_done   = wb.wb_err | wb.wb_ack | w_expired;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clock),
        .rst     (reset),
        .clear   (w_active & w_done),
        .enable  (w_active),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cyc_q       <= 1'b0;
            r_req_q       <= '0;
            r_read_data_q <= '0;
            r_bus_error_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cyc_q       <= w_cyc_d;
            r_req_q       <= w_req_d;
            r_read_data_q <= w_read_data_d;
            r_bus_error_q <= w_bus_error_d;
        end
    end

    // Next state
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: begin
                if (request) begin
                    w_state_d = (byte_select != 4'b0000) ? ACTIVE : RESPOND;
                end
            end
            ACTIVE: begin
                if (w_done) begin
                    w_state_d = RESPOND;
                end
            end
            RESPOND: w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Registered outputs; err beats ack, and ack beats a coincident timeout
    always_comb begin
        w_cyc_d       = r_cyc_q;
        w_req_d       = r_req_q;
        w_read_data_d = r_read_data_q;
        w_bus_error_d = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (request) begin
                    if (byte_select != 4'b0000) begin
                        w_cyc_d     = 1'b1;
                        w_req_d.we  = write_enable;
                        w_req_d.adr = c_ADR_W'(address[ADDRESS_WIDTH-1:2]);
                        w_req_d.dat = write_data;
                        w_req_d.sel = byte_select;
                    end else begin
                        w_read_data_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (wb.wb_err) begin
                    w_cyc_d       = 1'b0;
                    w_read_data_d = '0;
                    w_bus_error_d = 1'b1;
                end else if (wb.wb_ack) begin
                    w_cyc_d = 1'b0;
                    if (!r_req_q.we) begin
                        w_read_data_d = wb.wb_dat_i;
                    end
                end else if (w_expired) begin
                    w_cyc_d       = 1'b0;
                    w_read_data_d = '0;
                    w_bus_error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign stall     = request && (r_state_q != RESPOND);
    assign read_data = r_read_data_q;
    assign bus_error = r_bus_error_q;

    assign wb.wb_cyc   = r_cyc_q;
    assign wb.wb_stb   = r_cyc_q;
    assign wb.wb_we    = r_req_q.we;
    assign wb.wb_adr   = r_req_q.adr[ADDRESS_WIDTH-3:0];
    assign wb.wb_dat_o = r_req_q.dat;
    assign wb.wb_sel   = r_req_q.sel;

    assign w_unused = &{1'b0, address[1:0], r_req_q.adr};

endmodule

`default_nettype wire

// File: tb/tb_wishbone_bridge.sv
// ============================================================================
// Module   : tb_wishbone_bridge
// Purpose  : Self-checking bench for wishbone_bridge with a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wishbone_bridge;

    localparam int T = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        request;
    logic        write_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_select;
    logic [31:0] read_data;
    logic        stall;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rd;

    wishbone_bridge_if #(.ADDRESS_WIDTH(32)) wb ();

    wishbone_bridge #(
        .TIMEOUT_CYCLES (T),
        .ADDRESS_WIDTH  (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .request      (request),
        .write_enable (write_enable),
        .address      (address),
        .write_data   (write_data),
        .byte_select  (byte_select),
        .read_data    (read_data),
        .stall        (stall),
        .bus_error    (bus_error),
        .wb           (wb)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          stall_cycles;
        int          cyc_cycles;
        logic [31:0] rd;
        logic        be;
        logic        fields_ok;
        logic        be_early;
        logic        hung;
        logic        cyc_at_start;
    } obs_t;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one CPU access and plays a slave that answers on cyc cycle resp_at (0 = never).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] sel, input int resp_at, input logic ack,
                             input logic err, input logic [31:0] dati, input logic keep_req,
                             output obs_t o);
        int idx;
        idx = 0;
        o = '{default: 0};
        o.fields_ok = 1'b1;
        o.hung = 1'b1;
        o.cyc_at_start = wb.wb_cyc;
        request = 1'b1; write_enable = we; address = addr; write_data = wdata; byte_select = sel;
        #1;
        for (int n = 0; n < 40; n++) begin
            wb.wb_ack = 1'b0;
            wb.wb_err = 1'b0;
            wb.wb_dat_i = $urandom();
            if (wb.wb_cyc === 1'b1) begin
                idx++;
                if (wb.wb_stb !== 1'b1 || wb.wb_we !== we || wb.wb_adr !== addr[31:2] ||
                    wb.wb_dat_o !== wdata || wb.wb_sel !== sel)
                    o.fields_ok = 1'b0;
                if (idx == resp_at) begin
                    wb.wb_ack = ack; wb.wb_err = err; wb.wb_dat_i = dati;
                end
            end
            if (stall === 1'b0) begin
                o.rd = read_data; o.be = bus_error; o.hung = 1'b0;
                break;
            end
            if (bus_error !== 1'b0) o.be_early = 1'b1;
            o.stall_cycles++;
            step();
        end
        o.cyc_cycles = idx;
        wb.wb_ack = 1'b0;
        wb.wb_err = 1'b0;
        request = keep_req;
        step();
    endtask

    // Reference: sel==0 retires after one stalled cycle; otherwise the slave answer or the
    // timeout after T cycles ends the Wishbone cycle and the CPU retires one cycle later.
    task automatic model(input logic we, input logic [3:0] sel, input int resp_at, input logic ack,
                         input logic err, input logic [31:0] dati, output int e_stall,
                         output int e_cyc, output logic [31:0] e_rd, output logic e_be);
        logic answered;
        int   n;
        if (sel == 4'b0000) begin
            e_stall = 1; e_cyc = 0; e_rd = 32'h0; e_be = 1'b0;
        end else begin
            answered = (resp_at >= 1) && (resp_at <= T) && (ack || err);
            n = answered ? resp_at : T;
            e_cyc = n;
            e_stall = n + 1;
            if (!answered || err) begin
                e_rd = 32'h0; e_be = 1'b1;
            end else begin
                e_be = 1'b0;
                e_rd = we ? model_rd : dati;
            end
        end
        model_rd = e_rd;
    endtask

    task automatic test_reset();
        request = 1'b0; write_enable = 1'b0; address = '0; write_data = '0; byte_select = '0;
        wb.wb_ack = 1'b0; wb.wb_err = 1'b0; wb.wb_dat_i = '0;
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        model_rd = 32'h0;
        checks++; if (wb.wb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", wb.wb_cyc); end
        checks++; if (wb.wb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", wb.wb_stb); end
        checks++; if (wb.wb_adr !== 30'h0) begin errors++; $display("FAIL reset_adr got %h want 0", wb.wb_adr); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", read_data); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_be got %b want 0", bus_error); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    endtask

    task automatic test_load_zero_wait();
        obs_t o;
        int es, ec; logic [31:0] er; logic eb;
        model(1'b0, 4'hF, 1, 1'b1, 1'b0, 32'hDEADBEEF, es, ec, er, eb);
        do_access(1'b0, 32'h0000_1004, $urandom(), 4'hF, 1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, o);
        checks++; if (o.stall_cycles !== 2 || es !== 2) begin errors++; $display("FAIL load_stall got %0d want 2", o.stall_cycles); end
        checks++; if (o.cyc_cycles !== ec) begin errors++; $display("FAIL load_cyc got %0d want %0d", o.cyc_cycles, ec); end
        checks++; if (o.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rd got %h want deadbeef", o.rd); end
        checks++; if (o.be !== 1'b0 || o.be_early) begin errors++; $display("FAIL load_be got %b want 0", o.be); end
        checks++; if (!o.fields_ok) begin errors++; $display("FAIL load_fields got bad want adr=401 stable"); end
        checks++; if (wb.wb_cyc !== 1'b0) begin errors++; $display("FAIL load_cyc_drop got %b want 0", wb.wb_cyc); end
    endtask

    task automatic test_store_wait3();
        obs_t o;
        int es, ec; logic [31:0] er; logic eb;
        model(1'b1, 4'b0011, 4, 1'b1, 1'b0, 32'h0, es, ec, er, eb);
        do_access(1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 4, 1'b1, 1'b0, $urandom(), 1'b0, o);
        checks++; if (o.cyc_cycles !== 4 || ec !== 4) begin errors++; $display("FAIL store_cyc got %0d want 4", o.cyc_cycles); end
        checks++; if (o.stall_cycles !== es) begin errors++; $display("FAIL store_stall got %0d want %0d", o.stall_cycles, es); end
        checks++; if (!o.fields_ok) begin errors++; $display("FAIL store_fields got unstable want stable"); end
        checks++; if (o.rd !== er) begin errors++; $display("FAIL store_rd got %h want %h", o.rd, er); end
        checks++; if (o.be !== eb) begin errors++; $display("FAIL store_be got %b want %b", o.be, eb); end
        checks++; if (wb.wb_cyc !== 1'b0) begin errors++; $display("FAIL store_cyc_drop got %b want 0", wb.wb_cyc); end
    endtask

    task automatic test_err_and_ack();
        obs_t o;
        int es, ec; logic [31:0] er; logic eb;
        model(1'b0, 4'hF, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, es, ec, er, eb);
        do_access(1'b0, $urandom(), $urandom(), 4'hF, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, o);
        checks++; if (o.rd !== 32'h0) begin errors++; $display("FAIL errack_rd got %h want 0", o.rd); end
        checks++; if (o.be !== 1'b1 || eb !== 1'b1) begin errors++; $display("FAIL errack_be got %b want 1", o.be); end
        checks++; if (o.stall_cycles !== es) begin errors++; $display("FAIL errack_stall got %0d want %0d", o.stall_cycles, es); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL errack_pulse got %b want 0", bus_error); end
    endtask

    task automatic test_timeout();
        obs_t o;
        int es, ec; logic [31:0] er; logic eb;
        model(1'b0, 4'hF, 0, 1'b0, 1'b0, 32'h0, es, ec, er, eb);
        do_access(1'b0, $urandom(), $urandom(), 4'hF, 0, 1'b0, 1'b0, 32'h0, 1'b0, o);
        checks++; if (o.hung) begin errors++; $display("FAIL timeout_hang got stall stuck want release"); end
        checks++; if (o.cyc_cycles !== T || ec !== T) begin errors++; $display("FAIL timeout_cyc got %0d want %0d", o.cyc_cycles, T); end
        checks++; if (o.be !== 1'b1) begin errors++; $display("FAIL timeout_be got %b want 1", o.be); end
        checks++; if (o.stall_cycles !== es) begin errors++; $display("FAIL timeout_stall got %0d want %0d", o.stall_cycles, es); end
    endtask

    task automatic test_reset_mid_cycle();
        request = 1'b1; write_enable = 1'b0; address = 32'h0000_0040; byte_select = 4'hF;
        step();
        step();
        checks++; if (wb.wb_cyc !== 1'b1) begin errors++; $display("FAIL midrst_active got %b want 1", wb.wb_cyc); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_rd = 32'h0;
        checks++; if (wb.wb_cyc !== 1'b0 || wb.wb_stb !== 1'b0) begin errors++; $display("FAIL midrst_cyc got %b want 0", wb.wb_cyc); end
        checks++; if (stall !== request) begin errors++; $display("FAIL midrst_stall got %b want %b", stall, request); end
        checks++; if (read_data !== 32'h0 || bus_error !== 1'b0) begin errors++; $display("FAIL midrst_out got %h want 0", read_data); end
        request = 1'b0; wb.wb_ack = 1'b1; wb.wb_dat_i = 32'hA5A5_A5A5;
        step();
        step();
        wb.wb_ack = 1'b0;
        checks++; if (wb.wb_cyc !== 1'b0 || read_data !== 32'h0 || bus_error !== 1'b0)
            begin errors++; $display("FAIL late_ack got cyc=%b rd=%h want 0", wb.wb_cyc, read_data); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2, o3;
        int es, ec; logic [31:0] er; logic eb;
        model(1'b0, 4'hF, 1, 1'b1, 1'b0, 32'h1111_2222, es, ec, er, eb);
        do_access(1'b0, 32'h100, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h1111_2222, 1'b1, o1);
        checks++; if (o1.rd !== er) begin errors++; $display("FAIL b2b_first_rd got %h want %h", o1.rd, er); end
        model(1'b0, 4'hC, 2, 1'b1, 1'b0, 32'h3333_4444, es, ec, er, eb);
        do_access(1'b0, 32'h200, 32'h0, 4'hC, 2, 1'b1, 1'b0, 32'h3333_4444, 1'b1, o2);
        checks++; if (o2.cyc_at_start !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b want 0", o2.cyc_at_start); end
        checks++; if (o2.cyc_cycles !== ec || o2.stall_cycles !== es)
            begin errors++; $display("FAIL b2b_second got cyc=%0d stall=%0d want %0d %0d", o2.cyc_cycles, o2.stall_cycles, ec, es); end
        checks++; if (o2.rd !== er) begin errors++; $display("FAIL b2b_second_rd got %h want %h", o2.rd, er); end
        model(1'b0, 4'h0, 1, 1'b1, 1'b0, 32'h0, es, ec, er, eb);
        do_access(1'b0, 32'h300, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h5555_6666, 1'b0, o3);
        checks++; if (o3.cyc_cycles !== 0 || o3.stall_cycles !== 1)
            begin errors++; $display("FAIL b2b_sel0 got cyc=%0d stall=%0d want 0 1", o3.cyc_cycles, o3.stall_cycles); end
        checks++; if (o3.rd !== 32'h0 || o3.be !== 1'b0) begin errors++; $display("FAIL b2b_sel0_rd got %h want 0", o3.rd); end
    endtask

    task automatic test_random();
        obs_t o;
        int es, ec; logic [31:0] er; logic eb;
        logic we, ack, err, keep;
        logic [31:0] addr, wdata, dati;
        logic [3:0] sel;
        int resp_at, kind;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom()); addr = $urandom(); wdata = $urandom(); dati = $urandom();
            sel = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom());
            resp_at = $urandom_range(0, 6);
            kind = $urandom_range(0, 3);
            ack = (kind == 0) || (kind == 2);
            err = (kind == 1) || (kind == 2);
            keep = 1'($urandom());
            model(we, sel, resp_at, ack, err, dati, es, ec, er, eb);
            do_access(we, addr, wdata, sel, resp_at, ack, err, dati, keep, o);
            checks++;
            if (o.hung || o.stall_cycles !== es || o.cyc_cycles !== ec || o.rd !== er ||
                o.be !== eb || o.be_early || !o.fields_ok || o.cyc_at_start !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d got stall=%0d cyc=%0d rd=%h be=%b ok=%b want %0d %0d %h %b",
                         i, o.stall_cycles, o.cyc_cycles, o.rd, o.be, o.fields_ok, es, ec, er, eb);
            end
        end
        request = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait3();
        test_err_and_ack();
        test_timeout();
        test_reset_mid_cycle();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
